comparador_secuencial_param: RTL

//   Parametrised, registered magnitude comparator; next generation of the 8-bit sequential comparator.

---
 rtl/comparador_secuencial_param_if.sv | 31 +++
 rtl/comparador_secuencial_param.sv | 120 ++++++++++++
 2 files changed

// File: rtl/comparador_secuencial_param_if.sv
// Sample/result bundle for comparador_secuencial_param: the source drives operands and mode,
// the comparator returns registered flags, the debounced match and its run count.
interface comparador_secuencial_param_if #(
    parameter int WIDTH   = 8,
    parameter int CONFIRM = 3
);
    localparam int CNT_W = $clog2(CONFIRM + 1);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       mode;
    logic             out_valid;
    logic             q_raw;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             q;
    logic [CNT_W-1:0] run_cnt;
    logic             mode_err;

    modport master (
        output in_valid, A, B, mode,
        input  out_valid, q_raw, gt, lt, eq, q, run_cnt, mode_err
    );

    modport slave (
        input  in_valid, A, B, mode,
        output out_valid, q_raw, gt, lt, eq, q, run_cnt, mode_err
    );
endinterface

// File: rtl/comparador_secuencial_param.sv
// Registered magnitude comparator with run-time mode, valid handshake and N-hit debounced match.
// Define COMPARADOR_SIGNED_EN to compare A/B as two's-complement; default build compares unsigned.
module comparador_secuencial_param #(
    parameter int WIDTH   = 8,
    parameter int CONFIRM = 3
) (
    input logic clk,
    input logic rst,
    comparador_secuencial_param_if.slave bus
);
    localparam int               CNT_W   = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM);

    typedef enum logic [2:0] {
        MODE_EQ   = 3'b000,
        MODE_NE   = 3'b001,
        MODE_GT   = 3'b010,
        MODE_LT   = 3'b011,
        MODE_GE   = 3'b100,
        MODE_LE   = 3'b101,
        MODE_RSV6 = 3'b110,
        MODE_RSV7 = 3'b111
    } mode_e;

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    mode_e            mode_s;

    assign a_s    = bus.A;
    assign b_s    = bus.B;
    assign mode_s = mode_e'(bus.mode);

    logic             out_valid_q;
    logic             q_raw_q, q_raw_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             mode_err_q, mode_err_d;
    logic             q_q, q_d;
    logic [CNT_W-1:0] run_q, run_d;
    mode_e            last_mode_q;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        gt_d       = 1'b0;
        lt_d       = 1'b0;
        eq_d       = (a_s == b_s);
        q_raw_d    = 1'b0;
        mode_err_d = 1'b0;
        run_d      = '0;
        q_d        = 1'b0;

`ifdef COMPARADOR_SIGNED_EN
        gt_d = ($signed(a_s) > $signed(b_s));
        lt_d = ($signed(a_s) < $signed(b_s));
`else
        gt_d = (a_s > b_s);
        lt_d = (a_s < b_s);
`endif

        unique case (mode_s)
            MODE_EQ: q_raw_d = eq_d;
            MODE_NE: q_raw_d = !eq_d;
            MODE_GT: q_raw_d = gt_d;
            MODE_LT: q_raw_d = lt_d;
            MODE_GE: q_raw_d = gt_d || eq_d;
            MODE_LE: q_raw_d = lt_d || eq_d;
            default: mode_err_d = 1'b1;
        endcase

        // A mode switch starts a fresh run so a threshold never inherits hits from another test.
        if (!q_raw_d) begin
            run_d = '0;
        end else if (mode_s != last_mode_q) begin
            run_d = CNT_W'(1);
        end else if (run_q == CNT_MAX) begin
            run_d = CNT_MAX;
        end else begin
            run_d = run_q + CNT_W'(1);
        end

        q_d = (run_d == CNT_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            q_raw_q     <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            mode_err_q  <= 1'b0;
            q_q         <= 1'b0;
            run_q       <= '0;
            last_mode_q <= MODE_EQ;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                q_raw_q     <= q_raw_d;
                gt_q        <= gt_d;
                lt_q        <= lt_d;
                eq_q        <= eq_d;
                mode_err_q  <= mode_err_d;
                q_q         <= q_d;
                run_q       <= run_d;
                last_mode_q <= mode_s;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.q_raw     = q_raw_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.mode_err  = mode_err_q;
    assign bus.q         = q_q;
    assign bus.run_cnt   = run_q;
endmodule
